// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encoding, byte-lane selectors, the sign/zero extension
// selector with its helper function, and the latched request payload struct.
package dmem_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Byte lane selected by address bit 0 (little-endian).
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  // Extension mode for byte loads, driven by req_signed.
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  typedef struct packed {
    logic                  write;
    logic                  byte_acc;
    logic                  sgn;
    logic [BUS_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } dmem_req_t;

  function automatic logic [DATA_W-1:0] extend_byte(input logic [BYTE_W-1:0] b,
                                                    input logic mode);
    if (mode == EXT_SIGN) return {{(DATA_W-BYTE_W){b[BYTE_W-1]}}, b};
    return {{(DATA_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the processor and the responder.
// master: processor side (drives req_valid/req_* fields, receives ready and response)
// slave : responder side (drives req_ready, resp_valid, resp_rdata, resp_err)
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_byte;
  logic                  req_signed;
  logic [BUS_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_byte_ram.sv
// 2**ADDR_W x 16 synchronous RAM with per-lane write enables and a
// synchronous, enable-gated read register. No reset on contents or read data.
// Ports: clk; addr (word index); wbe[1:0] (lane write enables);
//        wdata; re (read enable); rdata (registered read data).
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Lane writes and read-old-data read share one port.
  always_ff @(posedge clk) begin
    if (wbe[LANE_LO]) mem[addr][BYTE_W-1:0]      <= wdata[BYTE_W-1:0];
    if (wbe[LANE_HI]) mem[addr][DATA_W-1:BYTE_W] <= wdata[DATA_W-1:BYTE_W];
    if (re)           rdata                       <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the 16-bit processor's data-memory port.
// Accepts one load/store at a time, services it against dmem_byte_ram after
// WAIT_CYCLES extra cycles, and returns a one-cycle resp_valid pulse.
// Ports: clk; reset (synchronous, active-high); bus (dmem_responder_if.slave).
// Parameters: ADDR_W (word-index width, 1..15), WAIT_CYCLES (0..15).
// Optional: define DMEM_ALIGN_CHECK_EN to flag odd-address word accesses with
// resp_err (no RAM write, zero read data); otherwise resp_err is tied to 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  dmem_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              ready_q;
  logic              valid_q;
  dmem_req_t         req_q;
  dmem_req_t         req_in;
  dmem_req_t         cur;

  // Response formatting info, captured together with the RAM read.
  logic              rd_zero;
  logic              rd_byte;
  logic              rd_lane;
  logic              rd_sgn;

  logic              accept;
  logic              enter_resp;
  logic              misalign;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_wbe;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rdata_fmt;
  logic              unused_addr_bits;

  assign req_in = '{write:    bus.req_write,
                    byte_acc: bus.req_byte,
                    sgn:      bus.req_signed,
                    addr:     bus.req_addr,
                    wdata:    bus.req_wdata};

  assign accept = ready_q && bus.req_valid && !reset;

  // With zero latency the RAM is accessed on the accept edge itself, so the
  // live bus fields feed the RAM while idle; otherwise the latched copy does.
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      (!reset && (state == WAIT) && (cnt == '0));
  assign cur        = (state == IDLE) ? req_in : req_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = !cur.byte_acc && cur.addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign ram_addr  = cur.addr[ADDR_W:1];
  assign ram_wdata = cur.byte_acc ? {cur.wdata[BYTE_W-1:0], cur.wdata[BYTE_W-1:0]}
                                  : cur.wdata;

  // Lane enables for the commit edge; a byte store touches only its lane.
  always_comb begin
    ram_wbe = 2'b00;
    if (enter_resp && cur.write && !misalign) begin
      if (!cur.byte_acc)                ram_wbe = 2'b11;
      else if (cur.addr[0] == LANE_HI)  ram_wbe = 2'b10;
      else                              ram_wbe = 2'b01;
    end
  end

  // Address bits above the word index are deliberately ignored (wrap-around).
  assign unused_addr_bits = ^cur.addr;

  dmem_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .wbe   (ram_wbe),
    .wdata (ram_wdata),
    .re    (enter_resp),
    .rdata (ram_q)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      req_q   <= '0;
      rd_zero <= 1'b1;
      rd_byte <= 1'b0;
      rd_lane <= LANE_LO;
      rd_sgn  <= EXT_ZERO;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_q   <= req_in;
            ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              valid_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            valid_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
      if (enter_resp) begin
        rd_zero <= cur.write || misalign;
        rd_byte <= cur.byte_acc;
        rd_lane <= cur.addr[0];
        rd_sgn  <= cur.sgn;
      end
    end
  end

  // Read data comes straight from the RAM read register; formatting state is
  // captured on the same edge, so the value holds until the next response.
  always_comb begin
    rdata_fmt = ram_q;
    if (rd_zero) begin
      rdata_fmt = '0;
    end else if (rd_byte) begin
      rdata_fmt = extend_byte((rd_lane == LANE_HI) ? ram_q[DATA_W-1:BYTE_W]
                                                   : ram_q[BYTE_W-1:0], rd_sgn);
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_fmt;

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  // Error flag is raised only for the response cycle of a misaligned access.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= enter_resp && misalign;
  end

  assign bus.resp_err = err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances cover the default
// configuration (ADDR_W=10, WAIT_CYCLES=2), a tiny wrapping RAM (ADDR_W=4) and
// zero latency (WAIT_CYCLES=0). Expected data comes from a byte-array model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_write, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  int          sel;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        obs_ready, obs_valid, obs_err;
  logic [15:0] obs_rdata;
  logic [15:0] last_rd;
  logic        last_err;
  logic [7:0]  mdl [3][2048];
  logic [16:0] expq [$];

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();
  dmem_responder_if if2 ();

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.req_write = req_write;   assign if1.req_write = req_write;   assign if2.req_write = req_write;
  assign if0.req_byte = req_byte;     assign if1.req_byte = req_byte;     assign if2.req_byte = req_byte;
  assign if0.req_signed = req_signed; assign if1.req_signed = req_signed; assign if2.req_signed = req_signed;
  assign if0.req_addr = req_addr;     assign if1.req_addr = req_addr;     assign if2.req_addr = req_addr;
  assign if0.req_wdata = req_wdata;   assign if1.req_wdata = req_wdata;   assign if2.req_wdata = req_wdata;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  dmem_responder #(.ADDR_W(4),  .WAIT_CYCLES(2)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  always_comb begin
    case (sel)
      1:       begin obs_ready = if1.req_ready; obs_valid = if1.resp_valid; obs_rdata = if1.resp_rdata; obs_err = if1.resp_err; end
      2:       begin obs_ready = if2.req_ready; obs_valid = if2.resp_valid; obs_rdata = if2.resp_rdata; obs_err = if2.resp_err; end
      default: begin obs_ready = if0.req_ready; obs_valid = if0.resp_valid; obs_rdata = if0.resp_rdata; obs_err = if0.resp_err; end
    endcase
  end

  function automatic int wait_of(input int s);
    return (s == 2) ? 0 : 2;
  endfunction

  function automatic int unsigned depth_of(input int s);
    return (s == 1) ? 16 : 1024;
  endfunction

  // Byte-addressed memory model; address wraps modulo the RAM size in bytes.
  function automatic void model(input int s, input bit w, input bit bt, input bit sg,
                                input logic [15:0] a, input logic [15:0] d,
                                output logic [15:0] rd, output logic er);
    int unsigned lo, hi;
    logic [7:0]  b;
    bit          mis;
    lo  = ((32'(a) >> 1) % depth_of(s)) * 2;
    hi  = lo + 1;
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = !bt && a[0];
`endif
    er = mis;
    rd = 16'h0000;
    if (mis) return;
    if (w) begin
      if (!bt) begin
        mdl[s][lo] = d[7:0];
        mdl[s][hi] = d[15:8];
      end else if (a[0]) mdl[s][hi] = d[7:0];
      else               mdl[s][lo] = d[7:0];
    end else if (bt) begin
      b  = a[0] ? mdl[s][hi] : mdl[s][lo];
      rd = sg ? {{8{b[7]}}, b} : {8'h00, b};
    end else begin
      rd = {mdl[s][hi], mdl[s][lo]};
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request through the handshake, checking latency and ready behaviour.
  task automatic do_req(input bit w, input bit bt, input bit sg,
                        input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic er);
    int lat;
    bit ready_ok;
    for (int k = 0; k < 50 && obs_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    req_write = w; req_byte = bt; req_signed = sg; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; ready_ok = 1'b1; rd = 16'hxxxx; er = 1'bx;
    for (int k = 0; k < 40; k++) begin
      if (obs_ready !== 1'b0) ready_ok = 1'b0;
      if (obs_valid === 1'b1) begin
        lat = k; rd = obs_rdata; er = obs_err;
        break;
      end
      @(posedge clk); #1;
    end
    chk("latency", 32'(lat), 32'(wait_of(sel)));
    chk("ready_low_while_busy", 32'(ready_ok), 32'd1);
    @(posedge clk); #1;
    chk("pulse_end_ready_back", {30'd0, obs_valid, obs_ready}, 32'b01);
  endtask

  task automatic xact(input bit w, input bit bt, input bit sg,
                      input logic [15:0] a, input logic [15:0] d, input string tag);
    logic [15:0] rd, erd;
    logic        er, eer;
    model(sel, w, bt, sg, a, d, erd, eer);
    do_req(w, bt, sg, a, d, rd, er);
    chk({tag, "_rdata"}, 32'(rd), 32'(erd));
    chk({tag, "_err"}, 32'(er), 32'(eer));
    last_rd  = rd;
    last_err = er;
  endtask

  task automatic rand_load();
    req_write  = 1'b0;
    req_byte   = 1'($urandom_range(0, 1));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = 16'h0100 + 16'($urandom_range(0, 15));
    req_wdata  = 16'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int          issued, got, last_t;
    bit          seen;
    logic [15:0] erd;
    logic        eer;
    logic [16:0] e17;

    sel = 0; reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    for (int s = 0; s < 3; s++) for (int i = 0; i < 2048; i++) mdl[s][i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_ready", 32'(obs_ready), 32'd1);
    chk("reset_valid", 32'(obs_valid), 32'd0);
    chk("reset_rdata", 32'(obs_rdata), 32'd0);
    chk("reset_err",   32'(obs_err),   32'd0);

    // Word store then load.
    xact(1, 0, 0, 16'h0010, 16'hBEEF, "st_beef");
    xact(0, 0, 0, 16'h0010, 16'h0000, "ld_beef");
    chk("ld_beef_lit", 32'(last_rd), 32'h0000BEEF);

    // Byte stores and sign/zero-extended byte loads.
    xact(1, 0, 0, 16'h0020, 16'h0000, "st_w20");
    xact(1, 1, 0, 16'h0021, 16'h0080, "st_b21");
    xact(1, 1, 0, 16'h0020, 16'h007F, "st_b20");
    xact(0, 0, 0, 16'h0020, 16'h0000, "ld_w20");
    chk("ld_w20_lit", 32'(last_rd), 32'h0000807F);
    xact(0, 1, 1, 16'h0021, 16'h0000, "ld_sb21");
    chk("ld_sb21_lit", 32'(last_rd), 32'h0000FF80);
    xact(0, 1, 0, 16'h0021, 16'h0000, "ld_ub21");
    chk("ld_ub21_lit", 32'(last_rd), 32'h00000080);
    repeat (3) @(posedge clk);
    #1 chk("rdata_hold", 32'(obs_rdata), 32'h00000080);

    // Wrap-around on the 16-word instance.
    sel = 1;
    xact(1, 0, 0, 16'h0002, 16'h1234, "wr_st");
    xact(0, 0, 0, 16'h0022, 16'h0000, "wr_ld");
    chk("wr_ld_lit", 32'(last_rd), 32'h00001234);

    // Reset during WAIT discards the store; request during reset is ignored.
    sel = 0;
    xact(1, 0, 0, 16'h0030, 16'h5555, "rst_pre");
    req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0030; req_wdata = 16'hAAAA; req_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; req_wdata = 16'hCCCC;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    chk("rst_ready", 32'(obs_ready), 32'd1);
    chk("rst_valid", 32'(obs_valid), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (obs_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_no_pulse", 32'(seen), 32'd0);
    xact(0, 0, 0, 16'h0030, 16'h0000, "rst_ld");
    chk("rst_ld_lit", 32'(last_rd), 32'h00005555);

`ifdef DMEM_ALIGN_CHECK_EN
    xact(1, 0, 0, 16'h0040, 16'h2222, "al_pre");
    xact(1, 0, 0, 16'h0041, 16'h1111, "al_st");
    chk("al_st_err_lit", 32'(last_err), 32'd1);
    chk("al_st_rdata_lit", 32'(last_rd), 32'd0);
    xact(0, 0, 0, 16'h0040, 16'h0000, "al_ld");
    chk("al_ld_lit", 32'(last_rd), 32'h00002222);
    xact(0, 1, 0, 16'h0041, 16'h0000, "al_bld");
    chk("al_bld_err_lit", 32'(last_err), 32'd0);
    chk("al_bld_lit", 32'(last_rd), 32'h00000022);
`endif

    // Randomized traffic on the default instance.
    for (int i = 0; i < 16; i++) xact(1, 0, 0, 16'h0200 + 16'(2 * i), 16'($urandom), "rnd0_fill");
    for (int i = 0; i < 30; i++)
      xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'h0200 + 16'($urandom_range(0, 31)), 16'($urandom), "rnd0");

    // Randomized full-range addresses on the wrapping instance.
    sel = 1;
    for (int i = 0; i < 16; i++) xact(1, 0, 0, 16'(2 * i), 16'($urandom), "rnd1_fill");
    for (int i = 0; i < 15; i++)
      xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom), 16'($urandom), "rnd1");

    // Zero latency: back-to-back loads with req_valid held high.
    sel = 2;
    for (int i = 0; i < 8; i++) xact(1, 0, 0, 16'h0100 + 16'(2 * i), 16'($urandom), "z_fill");
    rand_load();
    req_valid = 1'b1;
    issued = 0; got = 0; last_t = -1;
    for (int t = 0; t < 200 && got < 12; t++) begin
      if (obs_ready === 1'b1 && req_valid) begin
        model(2, req_write, req_byte, req_signed, req_addr, req_wdata, erd, eer);
        expq.push_back({eer, erd});
        issued++;
      end
      @(posedge clk); #1;
      if (obs_valid === 1'b1) begin
        chk("z_resp_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          e17 = expq.pop_front();
          chk("z_rdata", 32'(obs_rdata), 32'(e17[15:0]));
          chk("z_err", 32'(obs_err), 32'(e17[16]));
        end
        if (last_t >= 0) chk("z_interval", 32'(t - last_t), 32'd2);
        last_t = t;
        got++;
        if (issued < 12) rand_load();
        else             req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("z_got", 32'(got), 32'd12);
    chk("z_issued", 32'(issued), 32'd12);
    chk("z_queue_empty", 32'(expq.size()), 32'd0);
    @(posedge clk); #1;
    chk("z_no_extra", 32'(obs_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
